// File: rtl/clause_io_pkg.sv
// Shared types and helpers for the clause array loader: FSM state encoding,
// default clause width and the count clamp used when an operation starts.
package clause_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    UNLOAD,
    DRAIN,
    DONE
  } state_e;

  localparam int DEF_NUM_VARS = 8;
  localparam int CLAUSE_W     = DEF_NUM_VARS * 2;

  function automatic int clamp_count(input int num, input int num_clauses);
    return (num < num_clauses) ? num : num_clauses;
  endfunction

endpackage

// File: rtl/clause_array_loader_onehot_dec.sv
// Binary index to one-hot slot select; all zeros when the index is out of range.
module onehot_dec #(
  parameter int WIDTH_CNT = 4,
  parameter int NUM_OUT   = 8
) (
  input  logic [WIDTH_CNT-1:0] index,
  output logic [NUM_OUT-1:0]   onehot
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    onehot = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (index == WIDTH_CNT'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/clause_array_loader.sv
// Host-side sequencer for the clause array: streams clauses into consecutive
// slots (LOAD) or reads them back out as a valid/ready stream (UNLOAD).
module clause_array_loader
  import clause_io_pkg::*;
#(
  parameter int NUM_CLAUSES = 8,
  parameter int NUM_VARS    = CLAUSE_W / 2,
  parameter int WIDTH_C_LEN = 4,
  parameter int WIDTH_CNT   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start_i,
  input  logic [WIDTH_CNT-1:0]    load_num_i,
  input  logic                    unload_start_i,
  input  logic [WIDTH_CNT-1:0]    unload_num_i,
  output logic                    busy_o,
  output logic                    done_o,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [NUM_VARS*2-1:0]   s_clause_i,
  input  logic [WIDTH_C_LEN-1:0]  s_len_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [NUM_VARS*2-1:0]   m_clause_o,
  output logic [WIDTH_CNT-1:0]    m_index_o,
  output logic [NUM_CLAUSES-1:0]  wr_o,
  output logic [NUM_CLAUSES-1:0]  rd_o,
  output logic [NUM_VARS*2-1:0]   clause_o,
  output logic [WIDTH_C_LEN-1:0]  clause_len_o,
  input  logic [NUM_VARS*2-1:0]   clause_i
);

  localparam logic [WIDTH_CNT-1:0] ONE = WIDTH_CNT'(1);

  state_e                 state, state_nx;
  logic [WIDTH_CNT-1:0]   idx, count;
  logic [WIDTH_CNT-1:0]   sel_num, num_clamped;
  logic [NUM_CLAUSES-1:0] wr_dec, rd_dec;
  logic                   load_hs, issue, out_hs, last_idx;

  onehot_dec #(.WIDTH_CNT(WIDTH_CNT), .NUM_OUT(NUM_CLAUSES)) u_wr_dec (
    .index  (idx),
    .onehot (wr_dec)
  );

  onehot_dec #(.WIDTH_CNT(WIDTH_CNT), .NUM_OUT(NUM_CLAUSES)) u_rd_dec (
    .index  (idx),
    .onehot (rd_dec)
  );

  // LOAD has priority when both starts arrive together.
  assign sel_num     = load_start_i ? load_num_i : unload_num_i;
  assign num_clamped = WIDTH_CNT'(clamp_count(int'(sel_num), NUM_CLAUSES));
  assign last_idx    = (idx == count - ONE);
  assign out_hs      = m_valid_o & m_ready_i;

  // Handshake-facing outputs are gated by rst so an abort issues nothing more.
  always_comb begin
    s_ready_o = (state == LOAD) & ~rst;
    load_hs   = s_ready_o & s_valid_i;
    issue     = (state == UNLOAD) & ~rst & (~m_valid_o | m_ready_i) & (idx < count);
    rd_o      = issue ? rd_dec : '0;
    busy_o    = (state != IDLE);
    done_o    = (state == DONE) & ~rst;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (load_start_i) begin
          state_nx = (num_clamped == '0) ? DONE : LOAD;
        end else if (unload_start_i) begin
          state_nx = (num_clamped == '0) ? DONE : UNLOAD;
        end
      end
      LOAD:    if (load_hs && last_idx) state_nx = DONE;
      UNLOAD:  if (issue && last_idx)   state_nx = DRAIN;
      DRAIN:   if (out_hs)              state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      count        <= '0;
      wr_o         <= '0;
      clause_o     <= '0;
      clause_len_o <= '0;
      m_valid_o    <= 1'b0;
      m_clause_o   <= '0;
      m_index_o    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state <= state_nx;
      wr_o  <= '0;
      case (state)
        IDLE: begin
          if (load_start_i || unload_start_i) begin
            count <= num_clamped;
            idx   <= '0;
          end
        end
        LOAD: begin
          if (load_hs) begin
            wr_o         <= wr_dec;
            clause_o     <= s_clause_i;
            clause_len_o <= s_len_i;
            idx          <= idx + ONE;
          end
        end
        UNLOAD: begin
          if (issue) begin
            m_clause_o <= clause_i;
            m_index_o  <= idx;
            m_valid_o  <= 1'b1;
            idx        <= idx + ONE;
          end else if (out_hs) begin
            m_valid_o <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_hs) m_valid_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clause_array_loader.sv
// Scoreboard bench for clause_array_loader: stimulus pushes expected writes and
// read-back beats; a negedge monitor pops and compares whenever the DUT presents them.
module tb_clause_array_loader;

  localparam int NC = 8;
  localparam int NV = 8;
  localparam int CW = NV * 2;
  localparam int LW = 4;
  localparam int WC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start_i, unload_start_i;
  logic [WC-1:0] load_num_i, unload_num_i;
  logic          busy_o, done_o;
  logic          s_valid_i, s_ready_o;
  logic [CW-1:0] s_clause_i;
  logic [LW-1:0] s_len_i;
  logic          m_valid_o, m_ready_i;
  logic [CW-1:0] m_clause_o;
  logic [WC-1:0] m_index_o;
  logic [NC-1:0] wr_o, rd_o;
  logic [CW-1:0] clause_o;
  logic [LW-1:0] clause_len_o;
  logic [CW-1:0] clause_i;

  clause_array_loader #(
    .NUM_CLAUSES(NC), .NUM_VARS(NV), .WIDTH_C_LEN(LW), .WIDTH_CNT(WC)
  ) dut (
    .clk(clk), .rst(rst),
    .load_start_i(load_start_i), .load_num_i(load_num_i),
    .unload_start_i(unload_start_i), .unload_num_i(unload_num_i),
    .busy_o(busy_o), .done_o(done_o),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_clause_i(s_clause_i), .s_len_i(s_len_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_clause_o(m_clause_o), .m_index_o(m_index_o),
    .wr_o(wr_o), .rd_o(rd_o),
    .clause_o(clause_o), .clause_len_o(clause_len_o),
    .clause_i(clause_i)
  );

  always #5 clk = ~clk;

  // Array model: slot k reads back 16'hA000 + k.
  always_comb begin
    clause_i = '0;
    for (int k = 0; k < NC; k++) if (rd_o[k]) clause_i = CW'(16'hA000 + k);
  end

  typedef struct packed {
    logic [NC-1:0] wr;
    logic [CW-1:0] clause;
    logic [LW-1:0] len;
  } wr_exp_t;

  typedef struct packed {
    logic [WC-1:0] index;
    logic [CW-1:0] clause;
  } rd_exp_t;

  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];
  wr_exp_t we;
  rd_exp_t re;
  int  n_cmp = 0, n_err = 0, done_cnt = 0, exp_done = 0;
  bit  rd_allowed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_o != '0) begin
        if (wr_q.size() == 0) check("unexpected_wr", 32'(wr_o), 32'h0);
        else begin
          we = wr_q.pop_front();
          check("wr_o", 32'(wr_o), 32'(we.wr));
          check("clause_o", 32'(clause_o), 32'(we.clause));
          check("clause_len_o", 32'(clause_len_o), 32'(we.len));
        end
      end
      if (rd_o != '0) begin
        check("rd_allowed", 32'(rd_allowed), 32'h1);
        check("rd_not_stalled", 32'((!m_valid_o) || m_ready_i), 32'h1);
      end
      if (m_valid_o && m_ready_i) begin
        if (rd_q.size() == 0) check("unexpected_beat", 32'(m_index_o), 32'hFFFF);
        else begin
          re = rd_q.pop_front();
          check("m_index_o", 32'(m_index_o), 32'(re.index));
          check("m_clause_o", 32'(m_clause_o), 32'(re.clause));
        end
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int num);
    load_num_i   = WC'(num);
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
  endtask

  // One clause presented for a single cycle; s_ready_o is 1 throughout LOAD.
  task automatic send_clause(input int slot, input logic [CW-1:0] c, input logic [LW-1:0] l);
    s_valid_i  = 1'b1;
    s_clause_i = c;
    s_len_i    = l;
    wr_q.push_back('{wr: NC'(1) << slot, clause: c, len: l});
    tick();
    s_valid_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy_o), 32'h0);
    check({tag, "_done"}, 32'(done_o), 32'h0);
    check({tag, "_wr"}, 32'(wr_o), 32'h0);
    check({tag, "_rd"}, 32'(rd_o), 32'h0);
    check({tag, "_m_valid"}, 32'(m_valid_o), 32'h0);
    check({tag, "_s_ready"}, 32'(s_ready_o), 32'h0);
    check({tag, "_clause_o"}, 32'(clause_o), 32'h0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    load_start_i = 0; unload_start_i = 0; load_num_i = '0; unload_num_i = '0;
    s_valid_i = 0; s_clause_i = '0; s_len_i = '0; m_ready_i = 0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // LOAD 3 with valid pattern 1,0,1,1
    start_load(3);
    exp_done++;
    send_clause(0, 16'h1234, 4'd3);
    tick();
    send_clause(1, 16'h5A5A, 4'd7);
    send_clause(2, 16'hBEEF, 4'd1);
    check("load3_done", 32'(done_o), 32'h1);
    check("load3_busy_in_done", 32'(busy_o), 32'h1);
    tick();
    check("load3_busy_after", 32'(busy_o), 32'h0);
    check("load3_done_after", 32'(done_o), 32'h0);

    // LOAD 12 is clamped to 8 slots
    start_load(12);
    exp_done++;
    for (int i = 0; i < NC; i++) send_clause(i, CW'(16'h0100 + i), LW'(i + 1));
    check("load12_done", 32'(done_o), 32'h1);
    check("load12_s_ready_in_done", 32'(s_ready_o), 32'h0);
    tick();
    check("load12_busy_after", 32'(busy_o), 32'h0);

    // LOAD 0 goes straight to DONE
    start_load(0);
    exp_done++;
    check("load0_done", 32'(done_o), 32'h1);
    check("load0_s_ready", 32'(s_ready_o), 32'h0);
    check("load0_wr", 32'(wr_o), 32'h0);
    tick();
    check("load0_busy_after", 32'(busy_o), 32'h0);

    // Both starts together: LOAD wins, later unload start during busy ignored
    load_num_i = 4'd2; unload_num_i = 4'd2;
    load_start_i = 1'b1; unload_start_i = 1'b1;
    tick();
    load_start_i = 1'b0; unload_start_i = 1'b0;
    exp_done++;
    check("both_s_ready", 32'(s_ready_o), 32'h1);
    unload_start_i = 1'b1;
    tick();
    unload_start_i = 1'b0;
    send_clause(0, 16'hC001, 4'd2);
    send_clause(1, 16'hC002, 4'd4);
    check("both_done", 32'(done_o), 32'h1);
    tick();
    tick();
    check("both_busy_after", 32'(busy_o), 32'h0);
    check("both_m_valid", 32'(m_valid_o), 32'h0);

    // UNLOAD 4 with m_ready_i low in cycles 2..4
    rd_allowed = 1'b1;
    for (int i = 0; i < 4; i++) rd_q.push_back('{index: WC'(i), clause: CW'(16'hA000 + i)});
    unload_num_i = 4'd4;
    unload_start_i = 1'b1;
    tick();
    unload_start_i = 1'b0;
    exp_done++;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      m_ready_i = !(c >= 2 && c <= 4);
      tick();
      if (done_o) seen = 1'b1;
    end
    check("unload_done_in_budget", 32'(seen), 32'h1);
    m_ready_i = 1'b0;
    tick();
    check("unload_busy_after", 32'(busy_o), 32'h0);
    check("unload_m_valid_after", 32'(m_valid_o), 32'h0);
    rd_allowed = 1'b0;

    // Reset after 2 of 5 loads aborts without done
    start_load(5);
    send_clause(0, 16'hD000, 4'd5);
    send_clause(1, 16'hD001, 4'd6);
    tick();
    rst = 1'b1;
    tick();
    check_idle_outputs("abort");
    rst = 1'b0;
    tick();
    check("abort_still_idle", 32'(busy_o), 32'h0);
    start_load(1);
    exp_done++;
    send_clause(0, 16'hE000, 4'd9);
    check("reload_done", 32'(done_o), 32'h1);
    tick();
    tick();

    check("wr_queue_empty", 32'(wr_q.size()), 32'h0);
    check("rd_queue_empty", 32'(rd_q.size()), 32'h0);
    check("done_pulses", 32'(done_cnt), 32'(exp_done));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
